// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control decode plus iterative multiply/divide engine with HI/LO.
// Latency: decode combinational; MULT/DIV write HI/LO WIDTH+1 cycles after accept, divide-by-zero after 1.
// Backpressure: stall is raised for any md op while the engine is busy; nothing md-related is accepted then.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] md_result,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_by_zero
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
  logic [CNT_W-1:0] cnt;
  logic             neg_res, neg_rem, op_div;

  logic             md_op, accept, start_mul, start_div, b_zero, last_iter;
  logic             a_neg, b_neg, div_ok;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // md-op classification: 0100xx are HI/LO moves, 0110xx are MULT/MULTU/DIV/DIVU
  assign md_op     = valid_in && (ALUOp == 2'b10) && !Funct[2] &&
                     ((Funct[5:3] == 3'b010) || (Funct[5:3] == 3'b011));
  assign md_busy   = (state != IDLE);
  assign stall     = md_op && (md_busy || (state != IDLE));
  assign accept    = md_op && !stall;
  assign start_mul = accept && (Funct[5:1] == 5'b01100);
  assign start_div = accept && (Funct[5:1] == 5'b01101);
  assign b_zero    = (src_b == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Signed forms have Funct[0]=0; most-negative negates to itself, which is its unsigned magnitude
  assign a_neg = !Funct[0] && src_a[WIDTH-1];
  assign b_neg = !Funct[0] && src_b[WIDTH-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // One iteration step: shift-add for multiply, restoring subtract for divide
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_b};
  assign div_ok    = !div_trial[WIDTH];
  assign prod      = {acc_hi, acc_lo};
  assign prod_fix  = neg_res ? -prod : prod;

  // ALU control decode, independent of engine state
  always_comb begin
    alu_control = 4'b1111;
    case (ALUOp)
      2'b00: alu_control = 4'b0010;
      2'b01: alu_control = 4'b0110;
      2'b10: begin
        case (Funct)
          6'b100000, 6'b100001: alu_control = 4'b0010;
          6'b100010, 6'b100011: alu_control = 4'b0110;
          6'b100100: alu_control = 4'b0000;
          6'b100101: alu_control = 4'b0001;
          6'b100110: alu_control = 4'b0011;
          6'b100111: alu_control = 4'b1100;
          6'b101010: alu_control = 4'b0111;
          6'b101011: alu_control = 4'b1000;
          6'b000000: alu_control = 4'b0100;
          6'b000010: alu_control = 4'b0101;
          6'b000011: alu_control = 4'b1001;
          6'b000100: alu_control = 4'b1010;
          6'b000110: alu_control = 4'b1011;
          6'b000111: alu_control = 4'b1101;
          default:   alu_control = 4'b1111;
        endcase
      end
      default: begin
        case (Funct)
          6'b001000, 6'b001001: alu_control = 4'b0010;
          6'b001010: alu_control = 4'b0111;
          6'b001011: alu_control = 4'b1000;
          6'b001100: alu_control = 4'b0000;
          6'b001101: alu_control = 4'b0001;
          6'b001110: alu_control = 4'b0011;
          6'b001111: alu_control = 4'b1110;
          default:   alu_control = 4'b1111;
        endcase
      end
    endcase
  end

  // HI/LO read port, only driven for an MFHI/MFLO that is not stalled
  always_comb begin
    md_result = '0;
    if (accept && (Funct == F_MFHI)) md_result = hi;
    if (accept && (Funct == F_MFLO)) md_result = lo;
  end

  // Engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Engine next state: divide by zero skips iteration and goes straight to FIX
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_mul)      state_nxt = MUL;
        else if (start_div) state_nxt = b_zero ? FIX : DIV;
      end
      MUL:     if (last_iter) state_nxt = FIX;
      DIV:     if (last_iter) state_nxt = FIX;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, iteration, sign fix-up and HI/LO write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd_b      <= '0;
      cnt         <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      op_div      <= 1'b0;
      md_done     <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      md_done <= (state == FIX);
      if (accept && (Funct == F_MTHI)) hi <= src_a;
      if (accept && (Funct == F_MTLO)) lo <= src_a;
      if (start_mul || start_div) begin
        acc_hi      <= '0;
        // a zero divisor keeps the raw dividend so it can be returned in HI
        acc_lo      <= (start_div && b_zero) ? src_a : a_mag;
        opnd_b      <= b_mag;
        cnt         <= '0;
        neg_res     <= a_neg ^ b_neg;
        neg_rem     <= a_neg;
        op_div      <= start_div;
        div_by_zero <= start_div && b_zero;
      end
      case (state)
        MUL: begin
          {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
          cnt              <= cnt + 1'b1;
        end
        DIV: begin
          acc_hi <= div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          if (!op_div) begin
            {hi, lo} <= prod_fix;
          end else if (div_by_zero) begin
            hi <= acc_lo;
            lo <= '1;
          end else begin
            lo <= neg_res ? -acc_lo : acc_lo;
            hi <= neg_rem ? -acc_hi : acc_hi;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
